// File: rtl/msrv32_fetch_ctrl_pkg.sv
// Shared definitions for the msrv32 fetch controller.
//   pc_src_t      : PC-mux select codes (boot, epc, trap, next)
//   fc_state_e    : fetch-controller state encoding (2 bits, fully specified)
//   FC_BOOT_ADDR  : default reset PC
package msrv32_fetch_ctrl_pkg;

  typedef logic [1:0] pc_src_t;

  localparam pc_src_t PC_SRC_BOOT = 2'd0;
  localparam pc_src_t PC_SRC_EPC  = 2'd1;
  localparam pc_src_t PC_SRC_TRAP = 2'd2;
  localparam pc_src_t PC_SRC_NEXT = 2'd3;

  typedef enum logic [1:0] {
    FC_BOOT      = 2'd0,
    FC_RUN       = 2'd1,
    FC_HOLD_TRAP = 2'd2,
    FC_HOLD_MRET = 2'd3
  } fc_state_e;

  localparam logic [31:0] FC_BOOT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/msrv32_fetch_ctrl_if.sv
// Handshake bundle between the fetch controller, the PC mux, the CSR/trap
// logic and the instruction AHB port.
//   ahb_ready_in    : fetch accepted when 1
//   trap_taken_in   : trap/interrupt redirect pulse
//   mret_in         : MRET redirect pulse
//   pc_mux_in       : selected next PC from the PC mux
//   pc_src_out      : PC-mux select
//   pc_out          : registered PC
//   instr_valid_out : instruction at pc_out is valid for decode
//   flush_out       : redirect accepted, squash younger ops
//   stall_cnt_out   : saturating count of stalled cycles
// master drives the requests/ready, slave is the fetch controller.
interface msrv32_fetch_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import msrv32_fetch_ctrl_pkg::*;

  logic             ahb_ready_in;
  logic             trap_taken_in;
  logic             mret_in;
  logic [31:0]      pc_mux_in;
  pc_src_t          pc_src_out;
  logic [31:0]      pc_out;
  logic             instr_valid_out;
  logic             flush_out;
  logic [CNT_W-1:0] stall_cnt_out;

  modport master (
    output ahb_ready_in, trap_taken_in, mret_in, pc_mux_in,
    input  pc_src_out, pc_out, instr_valid_out, flush_out, stall_cnt_out
  );

  modport slave (
    input  ahb_ready_in, trap_taken_in, mret_in, pc_mux_in,
    output pc_src_out, pc_out, instr_valid_out, flush_out, stall_cnt_out
  );

endinterface

// File: rtl/msrv32_fetch_ctrl.sv
// PC-mux sequencer and PC register for the msrv32 core.
// Holds trap/mret redirects across AHB wait states and flags the first
// fetch after a redirect as a flush.
//   clk_in  : core clock
//   rst_in  : synchronous reset, active-high
//   bus     : msrv32_fetch_ctrl_if slave modport (see interface header)
//
// state        | meaning
// FC_BOOT      | waiting for the first fetch at the boot address
// FC_RUN       | sequential fetch, redirects accepted directly
// FC_HOLD_TRAP | trap redirect pending on a stalled bus
// FC_HOLD_MRET | mret redirect pending on a stalled bus
module msrv32_fetch_ctrl
  import msrv32_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = FC_BOOT_ADDR,
  parameter int          CNT_W        = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  msrv32_fetch_ctrl_if.slave   bus
);

  fc_state_e        r_state;
  logic [31:0]      r_pc;
  logic             r_valid;
  logic             r_flush;
  logic [CNT_W-1:0] r_stall_cnt;
  pc_src_t          w_pc_src;
  logic             w_stall;

  // In HOLD_MRET a late trap only upgrades the pending request; the select
  // stays on epc for that cycle and moves to trap once the state changes.
  always_comb begin
    w_pc_src = PC_SRC_BOOT;
    case (r_state)
      FC_BOOT:      w_pc_src = PC_SRC_BOOT;
      FC_RUN:       w_pc_src = bus.trap_taken_in ? PC_SRC_TRAP :
                               bus.mret_in       ? PC_SRC_EPC  : PC_SRC_NEXT;
      FC_HOLD_TRAP: w_pc_src = PC_SRC_TRAP;
      FC_HOLD_MRET: w_pc_src = PC_SRC_EPC;
      default:      w_pc_src = PC_SRC_BOOT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= FC_BOOT;
      r_pc    <= BOOT_ADDRESS;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      case (r_state)
        FC_BOOT: begin
          if (bus.ahb_ready_in) begin
            r_pc    <= bus.pc_mux_in;
            r_state <= FC_RUN;
          end
        end
        FC_RUN: begin
          if (bus.ahb_ready_in) begin
            r_pc <= bus.pc_mux_in;
            if (bus.trap_taken_in || bus.mret_in) r_flush <= 1'b1;
            else                                  r_valid <= 1'b1;
          end else if (bus.trap_taken_in) begin
            r_state <= FC_HOLD_TRAP;
          end else if (bus.mret_in) begin
            r_state <= FC_HOLD_MRET;
          end
        end
        FC_HOLD_TRAP: begin
          if (bus.ahb_ready_in) begin
            r_pc    <= bus.pc_mux_in;
            r_flush <= 1'b1;
            r_state <= FC_RUN;
          end
        end
        FC_HOLD_MRET: begin
          if (bus.trap_taken_in) begin
            r_state <= FC_HOLD_TRAP;
          end else if (bus.ahb_ready_in) begin
            r_pc    <= bus.pc_mux_in;
            r_flush <= 1'b1;
            r_state <= FC_RUN;
          end
        end
        default: r_state <= FC_BOOT;
      endcase
    end
  end

  assign w_stall = (r_state != FC_BOOT) && !bus.ahb_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in)                        r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.pc_src_out      = w_pc_src;
  assign bus.pc_out          = r_pc;
  assign bus.instr_valid_out = r_valid;
  assign bus.flush_out       = r_flush;
  assign bus.stall_cnt_out   = r_stall_cnt;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Self-checking bench for msrv32_fetch_ctrl. Two instances share stimulus:
// the default 16-bit stall counter and a 4-bit one for saturation.
// Expected values come from a redirect-request model (booted flag plus a
// pending-request slot) stepped once per clock.
module tb_msrv32_fetch_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  msrv32_fetch_ctrl_if #(.CNT_W(16)) bus ();
  msrv32_fetch_ctrl_if #(.CNT_W(4))  bus4 ();

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(BOOT), .CNT_W(16)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  msrv32_fetch_ctrl #(.BOOT_ADDRESS(BOOT), .CNT_W(4)) u_dut4 (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus4)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: pending 0=none, 1=mret, 2=trap
  bit          m_booted;
  int          m_pending;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_flush;
  int          m_cnt;
  int          m_cnt4;
  logic [31:0] epc_vec  = 32'h0000_0200;
  logic [31:0] trap_vec = 32'h0000_0100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_src(input bit trp, input bit mrt);
    if (!m_booted)       return 0;
    if (m_pending == 2)  return 2;
    if (m_pending == 1)  return 1;
    if (trp)             return 2;
    if (mrt)             return 1;
    return 3;
  endfunction

  task automatic model_reset();
    m_booted = 0; m_pending = 0; m_pc = BOOT;
    m_valid = 0; m_flush = 0; m_cnt = 0; m_cnt4 = 0;
  endtask

  task automatic model_step(input bit rst, input bit rdy, input bit trp,
                            input bit mrt, input logic [31:0] mux);
    int req;
    if (rst) begin
      model_reset();
      return;
    end
    m_valid = 0;
    m_flush = 0;
    if (m_booted && !rdy) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15)   m_cnt4++;
    end
    if (!m_booted) begin
      if (rdy) begin
        m_pc = mux;
        m_booted = 1;
      end
    end else if (m_pending == 1 && trp) begin
      m_pending = 2;  // trap overrides a waiting mret, even with ready high
    end else begin
      req = (m_pending != 0) ? m_pending : (trp ? 2 : (mrt ? 1 : 0));
      if (rdy) begin
        m_pc = mux;
        if (req != 0) m_flush = 1;
        else          m_valid = 1;
        m_pending = 0;
      end else begin
        m_pending = req;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit rdy, input bit trp, input bit mrt);
    int          src;
    logic [31:0] mux;
    @(negedge clk_in);
    src = model_src(trp, mrt);
    case (src)
      0:       mux = BOOT;
      1:       mux = epc_vec;
      2:       mux = trap_vec;
      default: mux = m_pc + 32'd4;
    endcase
    rst_in = rst;
    bus.ahb_ready_in  = rdy;  bus4.ahb_ready_in  = rdy;
    bus.trap_taken_in = trp;  bus4.trap_taken_in = trp;
    bus.mret_in       = mrt;  bus4.mret_in       = mrt;
    bus.pc_mux_in     = mux;  bus4.pc_mux_in     = mux;
    #1;
    chk("pc_src", {30'd0, bus.pc_src_out}, src);
    chk("pc", bus.pc_out, m_pc);
    chk("valid", {31'd0, bus.instr_valid_out}, {31'd0, m_valid});
    chk("flush", {31'd0, bus.flush_out}, {31'd0, m_flush});
    chk("stall_cnt", {16'd0, bus.stall_cnt_out}, m_cnt);
    chk("stall_cnt4", {28'd0, bus4.stall_cnt_out}, m_cnt4);
    @(posedge clk_in);
    model_step(rst, rdy, trp, mrt, mux);
  endtask

  initial begin
    bus.ahb_ready_in = 0;  bus4.ahb_ready_in = 0;
    bus.trap_taken_in = 0; bus4.trap_taken_in = 0;
    bus.mret_in = 0;       bus4.mret_in = 0;
    bus.pc_mux_in = '0;    bus4.pc_mux_in = '0;
    rst_in = 1;
    repeat (2) @(posedge clk_in);
    model_reset();

    // boot then sequential fetch 0,4,8
    repeat (4) cycle(0, 1, 0, 0);
    // three stalled cycles then resume
    repeat (3) cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 1, 0, 0);
    // simultaneous trap and mret with ready
    cycle(0, 1, 1, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    // mret stalled, trap upgrade, then ready
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0);
    // reset while holding a trap
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    // boot, then 20 stalled cycles saturate the narrow counter
    cycle(0, 1, 0, 0);
    repeat (20) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("cnt4_sat", {28'd0, bus4.stall_cnt_out}, 32'd15);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rdy, trp, mrt, rst;
      rdy = ($urandom_range(0, 9) < 7);
      trp = ($urandom_range(0, 9) == 0);
      mrt = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      epc_vec  = $urandom & 32'hFFFF_FFFC;
      trap_vec = $urandom & 32'hFFFF_FFFC;
      cycle(rst, rdy, trp, mrt);
    end
    cycle(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
